// File: rtl/cmd_q_pkg.sv
// Shared types and constants for the command queue controller.
package cmd_q_pkg;

  // Byte assembly state: waiting for the high byte or the low byte of a command.
  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_t;

  localparam int CMD_W        = 16;
  localparam int FAST_TMO_CYC = 1024;

  // Effective inter-byte timeout; simulation builds use a short fixed value.
  function automatic int tmo_sel(input int tmo_cyc, input bit fast_sim);
    return fast_sim ? FAST_TMO_CYC : tmo_cyc;
  endfunction

endpackage

// File: rtl/cmd_queue_ctrl_if.sv
// Byte-in / command-out handshake bundle between UART receiver, queue and cmd_proc.
interface cmd_queue_ctrl_if #(parameter int DEPTH = 4);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]                  rx_data;
  logic                        rx_rdy;
  logic                        clr_rx_rdy;
  logic [cmd_q_pkg::CMD_W-1:0] cmd;
  logic                        cmd_rdy;
  logic                        clr_cmd_rdy;
  logic                        flush;
  logic [CNT_W-1:0]            cmd_cnt;
  logic                        overflow;
  logic                        frame_err;

  // Queue controller side.
  modport slave (
    input  rx_data, rx_rdy, clr_cmd_rdy, flush,
    output clr_rx_rdy, cmd, cmd_rdy, cmd_cnt, overflow, frame_err
  );

  // Host side (byte source and command consumer).
  modport master (
    output rx_data, rx_rdy, clr_cmd_rdy, flush,
    input  clr_rx_rdy, cmd, cmd_rdy, cmd_cnt, overflow, frame_err
  );

endinterface

// File: rtl/cmd_fifo.sv
// Flop-based command FIFO. The head is kept in its own register so cmd holds
// its last value once the queue drains, and is cleared to zero by flush/reset.
module cmd_fifo
  import cmd_q_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [CMD_W-1:0]           din_i,
  input  logic                       flush_i,
  output logic [CMD_W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     cnt_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CMD_W-1:0] head_q, head_d;
  logic             push_eff, pop_eff;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == CNT_W'(DEPTH));
  // A pop on an empty queue is ignored; a push on a full queue only lands if a pop frees a slot.
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);
  assign rd_ptr_nxt = rd_ptr_q + 1'b1;

  assign dout_o = head_q;
  assign cnt_o  = cnt_q;

  // Next occupancy and next head-of-queue value.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    if (push_eff && !pop_eff)      cnt_d = cnt_q + 1'b1;
    else if (pop_eff && !push_eff) cnt_d = cnt_q - 1'b1;

    if (cnt_d != '0) begin
      if (pop_eff)      head_d = (cnt_q == CNT_W'(1)) ? din_i : mem_q[rd_ptr_nxt];
      else if (empty_o) head_d = din_i;
    end
  end

  // Storage, pointers, occupancy and head register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      if (push_eff) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_eff) rd_ptr_q <= rd_ptr_nxt;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/cmd_queue_ctrl.sv
// Assembles UART bytes into 16-bit commands (high byte first) and queues them for cmd_proc.
//
// state   | meaning
// WAIT_HI | idle, next byte received is a command high byte
// WAIT_LO | high byte held, waiting for low byte; inter-byte timer running
module cmd_queue_ctrl
  import cmd_q_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TMO_CYC  = 1_000_000,
  parameter bit FAST_SIM = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  cmd_queue_ctrl_if.slave  bus
);

  localparam int TMO_EFF = tmo_sel(TMO_CYC, FAST_SIM);
  localparam int TMR_W   = $clog2(TMO_EFF);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_EFF - 1);

  asm_state_t       state_q;
  logic [7:0]       hi_byte_q;
  logic [TMR_W-1:0] tmr_q;
  logic             frame_err_q;
  logic             overflow_q;

  logic             push, pop, timeout;
  logic             fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_dout;
  logic [$clog2(DEPTH):0] fifo_cnt;

  // Every presented byte is consumed in its own cycle, including during flush.
  assign bus.clr_rx_rdy = bus.rx_rdy & rst_n;

  assign push    = (state_q == WAIT_LO) && bus.rx_rdy && !bus.flush;
  assign pop     = bus.clr_cmd_rdy && !bus.flush;
  // A byte arriving on the last timer cycle still completes the command.
  assign timeout = (state_q == WAIT_LO) && !bus.rx_rdy && (tmr_q == TMR_LAST);

  // Assembly FSM with byte timer, frame error pulse and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_HI;
      hi_byte_q   <= '0;
      tmr_q       <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= WAIT_HI;
      hi_byte_q   <= '0;
      tmr_q       <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= timeout;
      // Full without a simultaneous pop means the completed command is lost.
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
      case (state_q)
        WAIT_HI: begin
          if (bus.rx_rdy) begin
            hi_byte_q <= bus.rx_data;
            tmr_q     <= '0;
            state_q   <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (bus.rx_rdy)        state_q <= WAIT_HI;
          else if (timeout)      state_q <= WAIT_HI;
          else if (tmr_q != TMR_LAST) tmr_q <= tmr_q + 1'b1;
        end
        default: state_q <= WAIT_HI;
      endcase
    end
  end

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({hi_byte_q, bus.rx_data}),
    .flush_i (bus.flush),
    .dout_o  (fifo_dout),
    .cnt_o   (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.cmd       = fifo_dout;
  assign bus.cmd_rdy   = !fifo_empty;
  assign bus.cmd_cnt   = fifo_cnt;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_cmd_queue_ctrl.sv
module tb_cmd_queue_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_queue_ctrl_if #(.DEPTH(DEPTH)) bus ();

  cmd_queue_ctrl #(.DEPTH(DEPTH), .TMO_CYC(1_000_000), .FAST_SIM(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic        st_m;
  logic [7:0]  hi_m;
  int          tmr_m;
  logic        ovf_m, fe_m;
  logic [15:0] cmd_m;
  logic [15:0] sb[$];

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       pop;
    int         cnt;
    logic       ovf;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    st_m = 1'b0; hi_m = '0; tmr_m = 0; ovf_m = 1'b0; fe_m = 1'b0; cmd_m = '0;
    sb.delete();
  endtask

  task automatic model_step(input logic rv, input logic [7:0] rd, input logic pop, input logic fl);
    logic pop_eff, push_m, fe_n;
    fe_n = 1'b0;
    if (fl) begin
      model_reset();
    end else begin
      pop_eff = pop && (sb.size() > 0);
      push_m  = st_m && rv;
      if (!st_m && rv) begin
        hi_m = rd; st_m = 1'b1; tmr_m = 0;
      end else if (st_m && rv) begin
        st_m = 1'b0;
      end else if (st_m) begin
        if (tmr_m == TMO - 1) begin fe_n = 1'b1; st_m = 1'b0; end
        else tmr_m++;
      end
      if (pop_eff) void'(sb.pop_front());
      if (push_m) begin
        if (sb.size() < DEPTH) sb.push_back({hi_m, rd});
        else ovf_m = 1'b1;
      end
      if (sb.size() > 0) cmd_m = sb[0];
      fe_m = fe_n;
    end
  endtask

  task automatic compare_model();
    check("cmd_cnt", 32'(bus.cmd_cnt), 32'(sb.size()));
    check("cmd_rdy", 32'(bus.cmd_rdy), 32'(sb.size() > 0));
    check("cmd", 32'(bus.cmd), 32'(cmd_m));
    check("overflow", 32'(bus.overflow), 32'(ovf_m));
    check("frame_err", 32'(bus.frame_err), 32'(fe_m));
  endtask

  // One clock cycle: drive at negedge, check the combinational clear, sample #1 after posedge.
  task automatic tick(input logic rv, input logic [7:0] rd, input logic pop, input logic fl);
    @(negedge clk);
    bus.rx_rdy = rv; bus.rx_data = rd; bus.clr_cmd_rdy = pop; bus.flush = fl;
    #1;
    check("clr_rx_rdy", 32'(bus.clr_rx_rdy), 32'(rv));
    @(posedge clk);
    #1;
    bus.rx_rdy = 1'b0; bus.clr_cmd_rdy = 1'b0; bus.flush = 1'b0;
    model_step(rv, rd, pop, fl);
    compare_model();
  endtask

  task automatic send_cmd(input logic [7:0] hi, input logic [7:0] lo, input logic pop);
    tick(1'b1, hi, 1'b0, 1'b0);
    tick(1'b1, lo, pop, 1'b0);
  endtask

  // Scoreboard pop: head must match the oldest expected command before it is consumed.
  task automatic pop_chk(input string name);
    if (sb.size() == 0) check({name, "_sb_empty"}, 32'(bus.cmd_rdy), 32'd1);
    else check(name, 32'(bus.cmd), 32'(sb[0]));
    tick(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic apply_vec(input int i);
    send_cmd(vecs[i].hi, vecs[i].lo, vecs[i].pop);
    check("vec_cnt", 32'(bus.cmd_cnt), 32'(vecs[i].cnt));
    check("vec_ovf", 32'(bus.overflow), 32'(vecs[i].ovf));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd"}, 32'(bus.cmd), 32'h0);
    check({tag, "_rdy"}, 32'(bus.cmd_rdy), 32'h0);
    check({tag, "_cnt"}, 32'(bus.cmd_cnt), 32'h0);
    check({tag, "_ovf"}, 32'(bus.overflow), 32'h0);
    check({tag, "_fe"}, 32'(bus.frame_err), 32'h0);
    check({tag, "_clr"}, 32'(bus.clr_rx_rdy), 32'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int cyc;

    vecs[0]  = '{8'hA5, 8'h3C, 1'b0, 1, 1'b0};
    vecs[1]  = '{8'h10, 8'h01, 1'b0, 1, 1'b0};
    vecs[2]  = '{8'h20, 8'h02, 1'b0, 2, 1'b0};
    vecs[3]  = '{8'h30, 8'h03, 1'b0, 3, 1'b0};
    vecs[4]  = '{8'h40, 8'h04, 1'b0, 4, 1'b0};
    vecs[5]  = '{8'h50, 8'h05, 1'b0, 4, 1'b1};
    vecs[6]  = '{8'h61, 8'h16, 1'b0, 1, 1'b0};
    vecs[7]  = '{8'h62, 8'h26, 1'b0, 2, 1'b0};
    vecs[8]  = '{8'h63, 8'h36, 1'b0, 3, 1'b0};
    vecs[9]  = '{8'h64, 8'h46, 1'b0, 4, 1'b0};
    vecs[10] = '{8'h70, 8'h07, 1'b1, 4, 1'b0};

    bus.rx_rdy = 1'b1; bus.rx_data = 8'hFF; bus.clr_cmd_rdy = 1'b0; bus.flush = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("por");
    bus.rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single command A5,3C
    apply_vec(0);
    check("a53c_cmd", 32'(bus.cmd), 32'h0000A53C);
    check("a53c_rdy", 32'(bus.cmd_rdy), 32'd1);
    pop_chk("pop_a53c");
    check("a53c_hold", 32'(bus.cmd), 32'h0000A53C);

    // Stream 5 without popping, then drain 4
    for (int i = 1; i <= 5; i++) apply_vec(i);
    for (int i = 0; i < 4; i++) pop_chk("pop_stream");
    check("stream_empty", 32'(bus.cmd_rdy), 32'd0);
    check("stream_last", 32'(bus.cmd), 32'h00004004);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    check("flush_ovf", 32'(bus.overflow), 32'd0);

    // Timeout with one command already queued
    send_cmd(8'h01, 8'h01, 1'b0);
    tick(1'b1, 8'h12, 1'b0, 1'b0);
    seen = 1'b0; cyc = 0;
    for (int k = 1; k <= TMO + 80 && !seen; k++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      if (bus.frame_err) begin seen = 1'b1; cyc = k; end
    end
    check("tmo_seen", 32'(seen), 32'd1);
    check("tmo_cycles", 32'(cyc), 32'(TMO));
    check("tmo_cnt", 32'(bus.cmd_cnt), 32'd1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    check("tmo_pulse", 32'(bus.frame_err), 32'd0);
    send_cmd(8'h34, 8'h56, 1'b0);
    pop_chk("pop_0101");
    check("tmo_3456", 32'(bus.cmd), 32'h00003456);
    pop_chk("pop_3456");

    // Full queue with simultaneous push and pop
    for (int i = 6; i <= 10; i++) apply_vec(i);
    for (int i = 0; i < 3; i++) pop_chk("pop_full");
    check("full_tail", 32'(bus.cmd), 32'h00007007);
    pop_chk("pop_tail");
    check("full_drained", 32'(bus.cmd_rdy), 32'd0);

    // Flush mid-assembly with two queued; a byte presented during flush is consumed and dropped
    send_cmd(8'h81, 8'h18, 1'b0);
    send_cmd(8'h82, 8'h28, 1'b0);
    tick(1'b1, 8'h99, 1'b0, 1'b0);
    tick(1'b1, 8'hEE, 1'b0, 1'b1);
    check("fl_cnt", 32'(bus.cmd_cnt), 32'd0);
    check("fl_rdy", 32'(bus.cmd_rdy), 32'd0);
    check("fl_cmd", 32'(bus.cmd), 32'h0);
    send_cmd(8'h77, 8'h88, 1'b0);
    check("fl_fresh", 32'(bus.cmd), 32'h00007788);

    // Asynchronous reset mid-stream
    send_cmd(8'hC1, 8'h1C, 1'b0);
    tick(1'b1, 8'hD0, 1'b0, 1'b0);
    #2;
    bus.rx_rdy = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    bus.rx_rdy = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_cmd(8'hE1, 8'h1E, 1'b0);
    check("arst_fresh", 32'(bus.cmd), 32'h0000E11E);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
